// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master and its wait timer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_DATA_W  = 32;
    localparam int DEFAULT_TIMEOUT = 16;
    localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles with Pready low; flags the cycle that must abort the transfer.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WAIT_CNT_W-1:0] EXPIRE_AT = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] r_count;

    // Clear wins over enable so a back-to-back SETUP always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WAIT_CNT_W'(1);
        end
    end

    assign o_expire = (r_count == EXPIRE_AT);

endmodule

// File: rtl/apb_master_gen2.sv
// APB master: turns a valid/ready request stream into APB transfers with
// a per-transfer wait timeout and a one-cycle registered response.
module apb_master_gen2
    import apb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                Pclk,
    input  logic                Presetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_wr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                Psel,
    output logic                Penable,
    output logic                Pwrite,
    output logic [ADDR_W-1:0]   Paddr,
    output logic [DATA_W-1:0]   PWdata,
    output logic [DATA_W/8-1:0] Pstrb,
    input  logic [DATA_W-1:0]   PRdata,
    input  logic                Pready,
    input  logic                Pslverr
);

    apb_state_e r_state;
    apb_state_e w_nextState;
    logic       w_expire;
    logic       w_inAccess;
    logic       w_done;
    logic       w_accept;

    assign w_inAccess = (r_state == ACCESS);
    assign w_done     = w_inAccess && (Pready || w_expire);
    assign req_ready  = (r_state == IDLE) || w_done;
    assign w_accept   = req_valid && req_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (Pclk),
        .rst_n    (Presetn),
        .i_clear  (w_accept),
        .i_enable (w_inAccess && !Pready),
        .o_expire (w_expire)
    );

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_nextState = SETUP;
            SETUP:   w_nextState = ACCESS;
            ACCESS:  if (w_done) w_nextState = req_valid ? SETUP : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // APB control follows the next state so Psel/Penable come straight from flops.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            Psel    <= 1'b0;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= '0;
            PWdata  <= '0;
            Pstrb   <= '0;
        end else begin
            Psel    <= (w_nextState != IDLE);
            Penable <= (w_nextState == ACCESS);
            if (w_accept) begin
                Pwrite <= req_wr;
                Paddr  <= req_addr;
                PWdata <= req_wr ? req_wdata : '0;
                Pstrb  <= req_wr ? req_strb : '0;
            end else if (w_done) begin
                Pwrite <= 1'b0;
                Paddr  <= '0;
                PWdata <= '0;
                Pstrb  <= '0;
            end
        end
    end

    // A completion with Pready low can only be the timeout abort.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= w_done;
            if (w_done) begin
                rsp_err     <= Pslverr || !Pready;
                rsp_timeout <= !Pready;
                rsp_rdata   <= (Pready && !Pwrite) ? PRdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_gen2.sv
// Self-checking bench for apb_master_gen2: directed and random transfers
// compared against a transaction-level model of the expected APB timeline.
module tb_apb_master_gen2;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
    } txn_t;

    logic        Pclk = 1'b0;
    logic        Presetn;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [7:0]  Paddr;
    logic [31:0] PWdata;
    logic [3:0]  Pstrb;
    logic [31:0] PRdata;
    logic        Pready;
    logic        Pslverr;

    int   vectors = 0;
    int   miscompares = 0;
    txn_t q[$];

    apb_master_gen2 #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .Pclk        (Pclk),
        .Presetn     (Presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wr      (req_wr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .Psel        (Psel),
        .Penable     (Penable),
        .Pwrite      (Pwrite),
        .Paddr       (Paddr),
        .PWdata      (PWdata),
        .Pstrb       (Pstrb),
        .PRdata      (PRdata),
        .Pready      (Pready),
        .Pslverr     (Pslverr)
    );

    always #5 Pclk = ~Pclk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Transaction-level model: how long ACCESS lasts and what the response must be.
    function automatic bit timedOut(input txn_t t);
        return t.waits >= TB_TIMEOUT;
    endfunction

    function automatic int accessLen(input txn_t t);
        return timedOut(t) ? TB_TIMEOUT : t.waits + 1;
    endfunction

    function automatic logic expErr(input txn_t t);
        return timedOut(t) ? 1'b1 : t.slverr;
    endfunction

    function automatic logic [31:0] expRdata(input txn_t t);
        return (timedOut(t) || t.wr) ? 32'h0 : t.rdata;
    endfunction

    function automatic txn_t mkTxn(input logic [7:0] a, input logic w, input logic [31:0] d,
                                   input logic [3:0] s, input int wt, input logic e,
                                   input logic [31:0] r);
        txn_t t;
        t.addr = a; t.wr = w; t.wdata = d; t.strb = s;
        t.waits = wt; t.slverr = e; t.rdata = r;
        return t;
    endfunction

    function automatic txn_t randTxn();
        return mkTxn(8'($urandom), 1'($urandom), $urandom, 4'($urandom),
                     int'($urandom_range(0, TB_TIMEOUT + 1)), 1'($urandom), $urandom);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic driveReq(input txn_t t);
        req_valid = 1'b1;
        req_addr  = t.addr;
        req_wr    = t.wr;
        req_wdata = t.wdata;
        req_strb  = t.strb;
    endtask

    task automatic driveIdleReq();
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_wr    = 1'($urandom);
        req_wdata = $urandom;
        req_strb  = 4'($urandom);
    endtask

    task automatic driveJunkSlave();
        Pready  = 1'($urandom);
        Pslverr = 1'($urandom);
        PRdata  = $urandom;
    endtask

    task automatic checkIdleBus(input string tag);
        checkOutput({tag, ".Psel"}, 32'(Psel), 32'h0);
        checkOutput({tag, ".Penable"}, 32'(Penable), 32'h0);
        checkOutput({tag, ".Paddr"}, 32'(Paddr), 32'h0);
        checkOutput({tag, ".Pwrite"}, 32'(Pwrite), 32'h0);
        checkOutput({tag, ".PWdata"}, PWdata, 32'h0);
        checkOutput({tag, ".Pstrb"}, 32'(Pstrb), 32'h0);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'h1);
    endtask

    task automatic checkRsp(input string tag, input txn_t t);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h1);
        checkOutput({tag, ".rsp_err"}, 32'(rsp_err), 32'(expErr(t)));
        checkOutput({tag, ".rsp_timeout"}, 32'(rsp_timeout), 32'(timedOut(t)));
        checkOutput({tag, ".rsp_rdata"}, rsp_rdata, expRdata(t));
    endtask

    task automatic checkHeldBus(input string tag, input txn_t t, input logic en);
        checkOutput({tag, ".Psel"}, 32'(Psel), 32'h1);
        checkOutput({tag, ".Penable"}, 32'(Penable), 32'(en));
        checkOutput({tag, ".Paddr"}, 32'(Paddr), 32'(t.addr));
        checkOutput({tag, ".Pwrite"}, 32'(Pwrite), 32'(t.wr));
        checkOutput({tag, ".PWdata"}, PWdata, t.wr ? t.wdata : 32'h0);
        checkOutput({tag, ".Pstrb"}, 32'(Pstrb), t.wr ? 32'(t.strb) : 32'h0);
    endtask

    // Runs every queued transaction back-to-back (req_valid held), then idles.
    task automatic applyStimulus();
        txn_t cur, nxt, prev;
        bit   havePrev = 0;
        bit   haveNext;
        int   n;
        @(posedge Pclk); #1;
        cur = q.pop_front();
        driveReq(cur);
        driveJunkSlave();
        #1;
        checkOutput("accept.req_ready", 32'(req_ready), 32'h1);
        checkOutput("accept.Psel", 32'(Psel), 32'h0);
        forever begin
            @(posedge Pclk); #1;
            haveNext = (q.size() > 0);
            if (haveNext) begin
                nxt = q[0];
                driveReq(nxt);
            end else begin
                driveIdleReq();
            end
            driveJunkSlave();
            #1;
            checkHeldBus("setup", cur, 1'b0);
            checkOutput("setup.req_ready", 32'(req_ready), 32'h0);
            if (havePrev) begin
                checkRsp("b2b", prev);
            end else begin
                checkOutput("setup.rsp_valid", 32'(rsp_valid), 32'h0);
            end
            n = accessLen(cur);
            for (int i = 0; i < n; i++) begin
                @(posedge Pclk); #1;
                Pready  = (i == cur.waits);
                Pslverr = Pready ? cur.slverr : 1'($urandom);
                PRdata  = Pready ? cur.rdata : $urandom;
                #1;
                checkHeldBus("access", cur, 1'b1);
                checkOutput("access.rsp_valid", 32'(rsp_valid), 32'h0);
                checkOutput("access.req_ready", 32'(req_ready), 32'(i == n - 1));
            end
            prev = cur;
            havePrev = 1;
            if (!haveNext) break;
            cur = q.pop_front();
        end
        @(posedge Pclk); #1;
        driveIdleReq();
        driveJunkSlave();
        #1;
        checkRsp("done", prev);
        checkIdleBus("done");
        @(posedge Pclk); #1;
        driveJunkSlave();
        #1;
        checkOutput("after.rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("after.rsp_err", 32'(rsp_err), 32'(expErr(prev)));
        checkOutput("after.rsp_timeout", 32'(rsp_timeout), 32'(timedOut(prev)));
        checkOutput("after.rsp_rdata", rsp_rdata, expRdata(prev));
        checkIdleBus("after");
    endtask

    initial begin
        Presetn = 1'b0;
        driveIdleReq();
        driveJunkSlave();
        #2;
        checkIdleBus("reset");
        checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset.rsp_err", 32'(rsp_err), 32'h0);
        checkOutput("reset.rsp_rdata", rsp_rdata, 32'h0);
        #20;
        Presetn = 1'b1;
        @(posedge Pclk); #2;
        checkIdleBus("postreset");

        $display("[TB] directed: single write, no wait");
        q.push_back(mkTxn(8'h3C, 1'b1, 32'hA5A5_0F0F, 4'hF, 0, 1'b0, 32'h1234_5678));
        applyStimulus();

        $display("[TB] directed: read with three wait states");
        q.push_back(mkTxn(8'h10, 1'b0, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'hDEAD_BEEF));
        applyStimulus();

        $display("[TB] directed: write with slave error");
        q.push_back(mkTxn(8'h44, 1'b1, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0));
        applyStimulus();

        $display("[TB] directed: Pready stuck low");
        q.push_back(mkTxn(8'h80, 1'b0, 32'h0, 4'h0, 100, 1'b0, 32'hCAFE_CAFE));
        applyStimulus();

        $display("[TB] directed: back-to-back pair");
        q.push_back(mkTxn(8'h01, 1'b1, 32'h1111_2222, 4'h5, 0, 1'b0, 32'h0));
        q.push_back(mkTxn(8'h02, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h3333_4444));
        applyStimulus();

        $display("[TB] random bursts");
        for (int b = 0; b < 12; b++) begin
            int len;
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) q.push_back(randTxn());
            applyStimulus();
        end

        $display("[TB] reset during ACCESS");
        @(posedge Pclk); #1;
        driveReq(mkTxn(8'h5A, 1'b1, 32'h7777_8888, 4'hF, 100, 1'b0, 32'h0));
        Pready = 1'b0;
        @(posedge Pclk); #1;
        driveIdleReq();
        @(posedge Pclk); #1;
        Pready = 1'b0;
        #1;
        checkOutput("midrst.Penable_before", 32'(Penable), 32'h1);
        #1;
        Presetn = 1'b0;
        #1;
        checkIdleBus("midrst");
        checkOutput("midrst.rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge Pclk); #1;
        checkOutput("midrst.hold_rsp_valid", 32'(rsp_valid), 32'h0);
        #3;
        Presetn = 1'b1;
        @(posedge Pclk); #2;
        checkOutput("midrst.release_rsp_valid", 32'(rsp_valid), 32'h0);
        checkIdleBus("midrst.release");
        q.push_back(mkTxn(8'h66, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h0F0F_A5A5));
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_master_gen2.md
APB_MASTER_GEN2 -- requirements
Module: apb_master_gen2

Interface
REQ-001 Parameter ADDR_W, default 8, Paddr/req_addr width (4..32).
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 8, 16 or 32.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles with Pready low before abort (2..255).
REQ-004 Pclk  in  1  clock; all state changes on rising edge.
REQ-005 Presetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_addr  in  ADDR_W  transfer address.
REQ-009 req_wr  in  1  1=write, 0=read.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 req_strb  in  DATA_W/8  byte-lane write strobes.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  slave error or timeout, valid with rsp_valid.
REQ-015 rsp_timeout  out  1  completion was a timeout abort.
REQ-016 Psel, Penable, Pwrite  out  1  APB control.
REQ-017 Paddr  out  ADDR_W; PWdata  out  DATA_W; Pstrb  out  DATA_W/8.
REQ-018 PRdata  in  DATA_W; Pready  in  1; Pslverr  in  1.

Function
REQ-019 FSM states IDLE, SETUP, ACCESS; SETUP lasts exactly one cycle, then ACCESS.
REQ-020 req_ready = (state==IDLE) || (state==ACCESS && (Pready || wait count==TIMEOUT-1)); combinational.
REQ-021 Accepted request: next cycle Psel=1, Penable=0, Paddr/Pwrite/PWdata/Pstrb loaded from req_*.
REQ-022 Reads: PWdata=0, Pstrb=0 regardless of req_wdata/req_strb.
REQ-023 ACCESS: Psel=1, Penable=1; Paddr, Pwrite, PWdata, Pstrb held stable until completion.
REQ-024 Completion on first ACCESS cycle with Pready=1: next cycle rsp_valid=1, rsp_err=Pslverr, rsp_timeout=0, rsp_rdata=PRdata for reads, 0 for writes.
REQ-025 Wait counter clears on SETUP entry, increments each ACCESS cycle with Pready=0.
REQ-026 Timeout: ACCESS cycle where Pready=0 and count==TIMEOUT-1 completes with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 On completion with req_valid=1: next state SETUP (back-to-back, Psel stays 1, Penable drops to 0); else IDLE with Psel=0, Penable=0, Paddr/PWdata/Pstrb/Pwrite=0.
REQ-028 Pready and Pslverr ignored outside ACCESS.
REQ-029 rsp_rdata/rsp_err/rsp_timeout hold last value between responses; rsp_valid never high two cycles from one transfer.
REQ-030 All APB and rsp_* outputs driven from registers.

Reset
REQ-031 Presetn low: state=IDLE immediately, all outputs except req_ready 0, wait counter 0.
REQ-032 Reset mid-transfer aborts it with no rsp_valid; first request after release accepted in IDLE.
REQ-033 req_ready=1 during and after reset (state IDLE).

Structure
REQ-034 Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS), default widths, timeout default.
REQ-035 One sub-module, apb_wait_timer: clear, enable, expire flag at TIMEOUT-1.

Verification
REQ-036 Write 0x3C, data 0xA5A5_0F0F, strb 0xF, Pready=1 at first ACCESS -> Psel 2 cycles, Penable 1 cycle, rsp_valid next cycle, rsp_err=0.
REQ-037 Read 0x10, Pready low 3 ACCESS cycles, PRdata=0xDEAD_BEEF -> Paddr stable 5 cycles, rsp_rdata=0xDEAD_BEEF, PWdata=0, Pstrb=0.
REQ-038 Write with Pslverr=1 at Pready -> rsp_err=1, rsp_timeout=0.
REQ-039 TIMEOUT=4, Pready stuck 0 -> 4 ACCESS cycles, then Psel=0, rsp_err=1, rsp_timeout=1.
REQ-040 Two back-to-back requests, req_valid held -> Psel continuous, Penable 1,0,1 pattern, two rsp_valid pulses.
REQ-041 Presetn low during ACCESS -> Psel/Penable 0 asynchronously, no rsp_valid, next request completes normally.
